q27_q45_monitor: RTL and testbench

- Read-back decoder for the H-bridge gate pulse pair Q2Q7/Q4Q5 produced by the pulse generator from a 16-bit width word.
- Observes both gate lines in the clk domain and measures each edge relative to the Q2Q7 rising edge.
- Reconstructs the width word {field3[15:10], field2[9:4], field1[3:0]} and reports it with status flags.
- Sits beside the generator; the host compares the read-back word against the word it loaded, for pulse-sequence self-test and interlock.

---
 rtl/q27_q45_pkg.sv | 31 +++
 rtl/q27_q45_edge_det.sv | 58 +++++
 rtl/q27_q45_monitor.sv | 193 +++++++++++++++++++
 tb/tb_q27_q45_monitor.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/q27_q45_pkg.sv
// Shared definitions for the Q2Q7/Q4Q5 gate-pulse generator and its read-back monitor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package q27_q45_pkg;

  // Monitor state encoding
  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    MEAS     = 2'd2,
    REPORT   = 2'd3
  } mon_state_t;

  // Width word field positions: {field3, field2, field1}
  localparam int F1_LSB = 0;
  localparam int F1_MSB = 3;
  localparam int F2_LSB = 4;
  localparam int F2_MSB = 9;
  localparam int F3_LSB = 10;
  localparam int F3_MSB = 15;

  localparam int F1_W = F1_MSB - F1_LSB + 1;
  localparam int F2_W = F2_MSB - F2_LSB + 1;
  localparam int F3_W = F3_MSB - F3_LSB + 1;

  // Error flag bit indices within err_out
  localparam int ERR_ORDER   = 0;
  localparam int ERR_RANGE   = 1;
  localparam int ERR_TIMEOUT = 2;

endpackage

// File: rtl/q27_q45_edge_det.sv
// Gate-line edge detector: optional 2-flop synchronizer (Q27Q45_MON_SYNC_EN), one delay flop, rise/fall strobes.
// Latency: strobes are combinational from the (synchronized) level; synchronizer adds 2 cycles when enabled.
// Backpressure: none; strobes are single-cycle and must be consumed when presented.
module q27_q45_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic q2q7_in,
  input  logic q4q5_in,
  output logic q27_lvl,
  output logic q45_lvl,
  output logic q27_rise,
  output logic q27_fall,
  output logic q45_rise,
  output logic q45_fall
);

`ifdef Q27Q45_MON_SYNC_EN
  logic [1:0] q27_sync;
  logic [1:0] q45_sync;

  // Two-stage synchronizers for the asynchronous gate lines
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q27_sync <= 2'b00;
      q45_sync <= 2'b00;
    end else begin
      q27_sync <= {q27_sync[0], q2q7_in};
      q45_sync <= {q45_sync[0], q4q5_in};
    end
  end

  assign q27_lvl = q27_sync[1];
  assign q45_lvl = q45_sync[1];
`else
  assign q27_lvl = q2q7_in;
  assign q45_lvl = q4q5_in;
`endif

  logic q27_d;
  logic q45_d;

  // Previous-cycle samples used as the edge reference
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q27_d <= 1'b0;
      q45_d <= 1'b0;
    end else begin
      q27_d <= q27_lvl;
      q45_d <= q45_lvl;
    end
  end

  assign q27_rise = q27_lvl & ~q27_d;
  assign q27_fall = ~q27_lvl & q27_d;
  assign q45_rise = q45_lvl & ~q45_d;
  assign q45_fall = ~q45_lvl & q45_d;

endmodule

// File: rtl/q27_q45_monitor.sv
// Read-back decoder for the Q2Q7/Q4Q5 gate pulse pair; rebuilds {field3, field2, field1} and error flags.
// Latency: width_valid 1 cycle after the Q2Q7 fall is detected (+2 cycles with Q27Q45_MON_SYNC_EN).
// Backpressure: none; width_valid is a one-cycle strobe, width_out/err_out hold until the next report.
module q27_q45_monitor
  import q27_q45_pkg::*;
#(
  parameter int CNT_W   = 6,
  parameter int TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        arm,
  input  logic        q2q7_in,
  input  logic        q4q5_in,
  output logic [15:0] width_out,
  output logic        width_valid,
  output logic [2:0]  err_out,
  output logic        busy
);

  localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] F1_MAX  = CNT_W'(15);

  logic q27_lvl, q45_lvl;
  logic q27_rise, q27_fall, q45_rise, q45_fall;

  q27_q45_edge_det u_edge (
    .clk      (clk),
    .reset    (reset),
    .q2q7_in  (q2q7_in),
    .q4q5_in  (q4q5_in),
    .q27_lvl  (q27_lvl),
    .q45_lvl  (q45_lvl),
    .q27_rise (q27_rise),
    .q27_fall (q27_fall),
    .q45_rise (q45_rise),
    .q45_fall (q45_fall)
  );

  mon_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       f1;
  logic [CNT_W-1:0] f2;
  logic [CNT_W-1:0] f3;
  logic             rise_seen;
  logic             fall_seen;
  logic             order_f;
  logic             range_f;
  logic             timeout_f;
  // Q4Q5 rise seen while idle; folded into the order flag of the next measurement
  logic             pend_order;

  logic [3:0]       n_f1;
  logic [CNT_W-1:0] n_f2;
  logic [CNT_W-1:0] n_f3;
  logic             n_rise_seen;
  logic             n_fall_seen;
  logic             n_order;
  logic             n_range;
  logic             n_timeout;
  logic             meas_done;

  // Next field/flag values for the current MEAS cycle, including the exit cycle
  always_comb begin
    n_f1        = f1;
    n_f2        = f2;
    n_f3        = f3;
    n_rise_seen = rise_seen;
    n_fall_seen = fall_seen;
    n_order     = order_f;
    n_range     = range_f;
    n_timeout   = 1'b0;
    meas_done   = 1'b0;

    // Only the first Q4Q5 rise is timed; any later one marks a sequence error
    if (q45_rise) begin
      if (rise_seen) begin
        n_order = 1'b1;
      end else begin
        n_rise_seen = 1'b1;
        if (cnt > F1_MAX) begin
          n_range = 1'b1;
          n_f1    = 4'd15;
        end else begin
          n_f1 = 4'(cnt);
        end
      end
    end

    if (q45_fall && !fall_seen) begin
      n_fall_seen = 1'b1;
      n_f2        = cnt;
    end

    // Q2Q7 fall wins over a timeout landing in the same cycle
    if (q27_fall) begin
      meas_done = 1'b1;
      n_f3      = cnt;
      if (q45_lvl) begin
        n_order = 1'b1;
        n_f2    = cnt;
      end
    end else if (cnt == TO_CNT) begin
      meas_done = 1'b1;
      n_timeout = 1'b1;
      n_f3      = TO_CNT;
    end
  end

  // Measurement FSM with registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= WAIT_LOW;
      cnt         <= '0;
      f1          <= '0;
      f2          <= '0;
      f3          <= '0;
      rise_seen   <= 1'b0;
      fall_seen   <= 1'b0;
      order_f     <= 1'b0;
      range_f     <= 1'b0;
      timeout_f   <= 1'b0;
      pend_order  <= 1'b0;
      width_out   <= '0;
      width_valid <= 1'b0;
      err_out     <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        WAIT_LOW: begin
          pend_order <= 1'b0;
          if (!q27_lvl && !q45_lvl) begin
            state <= IDLE;
          end
        end

        IDLE: begin
          if (q27_rise && arm) begin
            // This cycle is t0 (cnt = 0); the register holds the next cycle's count
            state      <= MEAS;
            busy       <= 1'b1;
            cnt        <= CNT_W'(1);
            f1         <= '0;
            f2         <= '0;
            f3         <= '0;
            rise_seen  <= q45_rise;
            fall_seen  <= 1'b0;
            range_f    <= 1'b0;
            timeout_f  <= 1'b0;
            order_f    <= pend_order | (q45_lvl & ~q45_rise);
            pend_order <= 1'b0;
          end else if (q45_rise) begin
            pend_order <= 1'b1;
          end
        end

        MEAS: begin
          f1        <= n_f1;
          f2        <= n_f2;
          f3        <= n_f3;
          rise_seen <= n_rise_seen;
          fall_seen <= n_fall_seen;
          order_f   <= n_order;
          range_f   <= n_range;
          timeout_f <= n_timeout;
          if (meas_done) begin
            state                       <= REPORT;
            width_valid                 <= 1'b1;
            width_out[F3_MSB:F3_LSB]    <= F3_W'(n_f3);
            width_out[F2_MSB:F2_LSB]    <= F2_W'(n_f2);
            width_out[F1_MSB:F1_LSB]    <= F1_W'(n_f1);
            err_out[ERR_TIMEOUT]        <= n_timeout;
            err_out[ERR_RANGE]          <= n_range;
            err_out[ERR_ORDER]          <= n_order;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        REPORT: begin
          width_valid <= 1'b0;
          busy        <= 1'b0;
          state       <= timeout_f ? WAIT_LOW : IDLE;
        end

        default: begin
          state <= WAIT_LOW;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_q27_q45_monitor.sv
// Directed-vector bench for q27_q45_monitor with a report scoreboard.
// Latency: expected strobe cycle is carried in each scoreboard entry.
// Backpressure: n/a.
module tb_q27_q45_monitor;

`ifdef Q27Q45_MON_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        arm = 1'b0;
  logic        q2q7 = 1'b0;
  logic        q4q5 = 1'b0;
  logic [15:0] width_out;
  logic        width_valid;
  logic [2:0]  err_out;
  logic        busy;

  always #5 clk = ~clk;

  q27_q45_monitor #(.CNT_W(6), .TIMEOUT(63)) dut (
    .clk         (clk),
    .reset       (reset),
    .arm         (arm),
    .q2q7_in     (q2q7),
    .q4q5_in     (q4q5),
    .width_out   (width_out),
    .width_valid (width_valid),
    .err_out     (err_out),
    .busy        (busy)
  );

  typedef struct {
    logic [15:0] w;
    logic [2:0]  e;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected report
  always @(negedge clk) begin
    if (reset && width_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_report: got width 0x%h err %b, required no report (cycle %0d)",
                 width_out, err_out, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("width_out", 32'(width_out), 32'(e.w));
        check("err_out", 32'(err_out), 32'(e.e));
        check("strobe_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Drive one Q2Q7 pulse of hi cycles; Q4Q5 high for offsets [r4, f4) relative to the Q2Q7 rise
  task automatic pulse(input int hi, input int r4, input int f4, input logic rep,
                       input logic [15:0] w, input logic [2:0] e, input int off);
    int total;
    total = ((hi > f4) ? hi : f4) + 3;
    if (rep) exp_q.push_back('{w, e, cyc + off + SYNC_LAT});
    for (int k = 0; k < total; k++) begin
      q2q7 = (k < hi);
      q4q5 = (r4 >= 0) && (k >= r4) && ((f4 < 0) || (k < f4));
      @(posedge clk); #1;
      if (k == 5 && hi > 6) check("busy_meas", 32'(busy), 32'(rep));
    end
    q2q7 = 1'b0;
    q4q5 = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_width_out", 32'(width_out), 32'd0);
    check("rst_width_valid", 32'(width_valid), 32'd0);
    check("rst_err_out", 32'(err_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    arm   = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end

    // Nominal word 0x50A3: field3 = 20, field2 = 10, field1 = 3
    pulse(20, 3, 10, 1'b1, 16'h50A3, 3'b000, 21);
    // Q2Q7 stuck high for 70 cycles: timeout, field3 = 63
    pulse(70, -1, -1, 1'b1, 16'hFC00, 3'b100, 64);
    // Q4Q5 rise at 20 saturates field1: {30, 25, 15}
    pulse(30, 20, 25, 1'b1, 16'h799F, 3'b010, 31);
    // Q4Q5 still high at Q2Q7 fall: {12, 12, 4}, order
    pulse(12, 4, 14, 1'b1, 16'h30C4, 3'b001, 13);
    // Q4Q5 rises with Q2Q7: {6, 2, 0}
    pulse(6, 0, 2, 1'b1, 16'h1820, 3'b000, 7);
    // Stray Q4Q5 pulse while idle flags order on the next measurement: {10, 6, 3}
    pulse(0, 1, 3, 1'b0, 16'h0000, 3'b000, 0);
    pulse(10, 3, 6, 1'b1, 16'h2863, 3'b001, 11);

    // Reset in the middle of a measurement: outputs clear, no report for that pulse
    q2q7 = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #1;
    check("midrst_width_out", 32'(width_out), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_err_out", 32'(err_out), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
    end
    q2q7 = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    // Next clean pulse: {16, 8, 4}
    pulse(16, 4, 8, 1'b1, 16'h4084, 3'b000, 17);

    // Unarmed pulse is ignored; the same pulse armed gives {8, 0, 0}
    arm = 1'b0;
    pulse(8, -1, -1, 1'b0, 16'h0000, 3'b000, 0);
    arm = 1'b1;
    pulse(8, -1, -1, 1'b1, 16'h2000, 3'b000, 9);

    repeat (10) begin
      @(posedge clk); #1;
    end
    check("reports_outstanding", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
